// File: rtl/bg_object_array_if.sv
// Control and output bundle for the background-object scroller.
// The master side drives game-frame control; the slave side (the scroller)
// returns packed per-slot positions, activity flags and sprite types.
interface bg_object_array_if #(
   parameter int NUM_OBJ = 3,
   parameter int POS_W   = 10,
   parameter int CONV    = 0
);
   logic                              tick;
   logic                              halt;
   logic [2:0]                        speed;
   logic                              spawn_en;
   logic [7:0]                        rng;
   logic [NUM_OBJ*(POS_W-CONV)-1:0]   obj_pos;
   logic [NUM_OBJ-1:0]                obj_active;
   logic [2*NUM_OBJ-1:0]              obj_type;
   logic                              spawn_pulse;

   modport master (
      output tick, halt, speed, spawn_en, rng,
      input  obj_pos, obj_active, obj_type, spawn_pulse
   );

   modport slave (
      input  tick, halt, speed, spawn_en, rng,
      output obj_pos, obj_active, obj_type, spawn_pulse
   );
endinterface

// File: rtl/bg_object_array.sv
// Multi-slot background-decoration scroller. Each slot scrolls left by
// 'speed' on every active tick and despawns at the left edge; free slots are
// refilled just past the right edge with a random offset and sprite type,
// with at least MIN_GAP scrolled pixels between consecutive spawns.
module bg_object_array #(
   parameter int NUM_OBJ  = 3,
   parameter int POS_W    = 10,
   parameter int CONV     = 0,
   parameter int SPAWN_X  = 640,
   parameter int RNG_BITS = 5,
   parameter int MIN_GAP  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   bg_object_array_if.slave  bus
);
   localparam int OUT_W = POS_W - CONV;
   localparam int GAP_W = $clog2(MIN_GAP + 8);

   // Configuration sanity: the farthest spawn position must fit in POS_W.
   if (SPAWN_X + (1 << RNG_BITS) - 1 >= (1 << POS_W)) begin : g_spawn_range_bad
      $error("bg_object_array: SPAWN_X plus max random offset exceeds POS_W");
   end
   if (NUM_OBJ < 1 || NUM_OBJ > 8) begin : g_num_obj_bad
      $error("bg_object_array: NUM_OBJ must be 1..8");
   end
   if (RNG_BITS < 1 || RNG_BITS > 6) begin : g_rng_bits_bad
      $error("bg_object_array: RNG_BITS must be 1..6");
   end

   logic [POS_W-1:0]     pos_reg  [NUM_OBJ];
   logic [POS_W-1:0]     pos_next [NUM_OBJ];
   logic [NUM_OBJ-1:0]   active_reg, active_next;
   logic [2*NUM_OBJ-1:0] type_reg, type_next;
   logic [GAP_W-1:0]     gap_reg, gap_next;
   logic [GAP_W-1:0]     gap_add, gap_sum;
   logic                 pulse_reg;

   logic                 active_tick;
   logic [POS_W-1:0]     speed_ext;
   logic [POS_W-1:0]     spawn_pos;
   logic [NUM_OBJ-1:0]   free_vec;
   logic [NUM_OBJ-1:0]   spawn_sel;
   logic                 do_spawn;
   logic                 unused_rng;

   assign active_tick = bus.tick & ~bus.halt;
   assign speed_ext   = POS_W'(bus.speed);
   assign spawn_pos   = POS_W'(SPAWN_X) + POS_W'(bus.rng[RNG_BITS+1:2]);
   assign unused_rng  = ^bus.rng;

   // Slots free at the start of the tick; a slot despawning this tick is
   // still marked active here, so it only becomes reusable on the next tick.
   assign free_vec  = ~active_reg;
   assign spawn_sel = free_vec & (~free_vec + NUM_OBJ'(1));

   // Gap including this tick's scroll, saturated. Spawning is judged on this
   // value so that a new object lands exactly MIN_GAP pixels behind the
   // previous one (the spawned object itself does not move on its spawn tick).
   always_comb begin
      gap_add = gap_reg + GAP_W'(bus.speed);
      gap_sum = (gap_add >= GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap_add;
   end

   assign do_spawn = bus.spawn_en & (gap_sum >= GAP_W'(MIN_GAP)) & (|free_vec);
   assign gap_next = do_spawn ? '0 : gap_sum;

   // Per-slot next state: scroll/despawn active slots, fill the chosen free slot.
   always_comb begin
      active_next = active_reg;
      type_next   = type_reg;
      for (int i = 0; i < NUM_OBJ; i++) begin
         pos_next[i] = pos_reg[i];
         if (active_reg[i]) begin
            if (pos_reg[i] <= speed_ext) begin
               active_next[i] = 1'b0;
               pos_next[i]    = '0;
            end else begin
               pos_next[i] = pos_reg[i] - speed_ext;
            end
         end else if (do_spawn && spawn_sel[i]) begin
            active_next[i]      = 1'b1;
            pos_next[i]         = spawn_pos;
            type_next[2*i +: 2] = bus.rng[1:0];
         end
      end
   end

   // State register: advances only on active ticks; pulse marks a spawn tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            pos_reg[i] <= '0;
         end
         active_reg <= '0;
         type_reg   <= '0;
         gap_reg    <= GAP_W'(MIN_GAP);
         pulse_reg  <= 1'b0;
      end else if (active_tick) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            pos_reg[i] <= pos_next[i];
         end
         active_reg <= active_next;
         type_reg   <= type_next;
         gap_reg    <= gap_next;
         pulse_reg  <= do_spawn;
      end else begin
         pulse_reg  <= 1'b0;
      end
   end

   // Output packing: each slot reports its position at reduced resolution.
   for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_out
      assign bus.obj_pos[gi*OUT_W +: OUT_W] = pos_reg[gi][POS_W-1:CONV];
   end

   assign bus.obj_active  = active_reg;
   assign bus.obj_type    = type_reg;
   assign bus.spawn_pulse = pulse_reg;
endmodule

// File: tb/tb_bg_object_array.sv
// Bench for bg_object_array: directed vector table, hand sequences for the
// despawn/respawn, halt and reset corners, and randomized traffic against a
// behavioural model. A full-resolution and a CONV=2 instance run side by side.
module tb_bg_object_array;
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick, halt, spawn_en;
   logic [2:0] speed;
   logic [7:0] rng;

   int tests_run = 0;
   int tests_failed = 0;

   bg_object_array_if #(.NUM_OBJ(N), .POS_W(10), .CONV(0)) bus0 ();
   bg_object_array_if #(.NUM_OBJ(N), .POS_W(10), .CONV(2)) bus2 ();

   assign bus0.tick = tick;  assign bus0.halt = halt;  assign bus0.speed = speed;
   assign bus0.spawn_en = spawn_en;  assign bus0.rng = rng;
   assign bus2.tick = tick;  assign bus2.halt = halt;  assign bus2.speed = speed;
   assign bus2.spawn_en = spawn_en;  assign bus2.rng = rng;

   bg_object_array #(.NUM_OBJ(N), .POS_W(10), .CONV(0), .SPAWN_X(640),
                     .RNG_BITS(5), .MIN_GAP(64))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   bg_object_array #(.NUM_OBJ(N), .POS_W(10), .CONV(2), .SPAWN_X(640),
                     .RNG_BITS(5), .MIN_GAP(64))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   // Behavioural model: plain integers following the scroll/spawn rules.
   int m_pos [N];
   int m_act [N];
   int m_typ [N];
   int m_gap;
   int m_pulse;

   function automatic void model_step(input logic rn, input logic t, input logic h,
                                      input int sp, input logic en, input int r);
      int first_free;
      int gap_after;
      bit spawn;
      if (!rn) begin
         for (int i = 0; i < N; i++) begin m_pos[i] = 0; m_act[i] = 0; m_typ[i] = 0; end
         m_gap = 64; m_pulse = 0;
         return;
      end
      if (!(t && !h)) begin m_pulse = 0; return; end
      first_free = -1;
      for (int i = 0; i < N; i++) if (m_act[i] == 0 && first_free < 0) first_free = i;
      gap_after = (m_gap + sp > 64) ? 64 : m_gap + sp;
      spawn = en && gap_after >= 64 && first_free >= 0;
      for (int i = 0; i < N; i++) begin
         if (m_act[i] != 0) begin
            if (m_pos[i] <= sp) begin m_act[i] = 0; m_pos[i] = 0; end
            else m_pos[i] = m_pos[i] - sp;
         end
      end
      if (spawn) begin
         m_pos[first_free] = 640 + ((r >> 2) % 32);
         m_typ[first_free] = r % 4;
         m_act[first_free] = 1;
         m_gap = 0;
      end else begin
         m_gap = gap_after;
      end
      m_pulse = spawn ? 1 : 0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [29:0] e_pos0;
      logic [23:0] e_pos2;
      logic [2:0]  e_act;
      logic [5:0]  e_typ;
      for (int i = 0; i < N; i++) begin
         e_pos0[i*10 +: 10] = 10'(m_pos[i]);
         e_pos2[i*8 +: 8]   = 8'(m_pos[i] / 4);
         e_act[i]           = (m_act[i] != 0);
         e_typ[2*i +: 2]    = 2'(m_typ[i]);
      end
      chk({tag, "_act"},   bus0.obj_active, e_act);
      chk({tag, "_type"},  bus0.obj_type, e_typ);
      chk({tag, "_pos"},   bus0.obj_pos, e_pos0);
      chk({tag, "_pulse"}, bus0.spawn_pulse, m_pulse[0]);
      chk({tag, "_c2act"}, bus2.obj_active, e_act);
      chk({tag, "_c2pos"}, bus2.obj_pos, e_pos2);
      chk({tag, "_c2pulse"}, bus2.spawn_pulse, m_pulse[0]);
   endtask

   // One clock: drive at negedge, update model on posedge, check at next negedge.
   task automatic cyc(input logic t, input logic h, input logic [2:0] sp, input logic en,
                      input logic [7:0] r, input logic rn, input string tag);
      tick = t; halt = h; speed = sp; spawn_en = en; rng = r; rst_n = rn;
      @(posedge clk);
      model_step(rn, t, h, int'(sp), en, int'(r));
      @(negedge clk);
      compare_all(tag);
   endtask

   function automatic logic [9:0] slot_pos(input int i);
      logic [29:0] v;
      v = bus0.obj_pos;
      return v[i*10 +: 10];
   endfunction

   typedef struct {
      logic       tick;
      logic [2:0] speed;
      logic [7:0] rng;
      logic [2:0] exp_act;
      logic [9:0] exp_pos0;
      logic [9:0] exp_pos1;
      logic       exp_pulse;
   } vec_t;

   vec_t vecs [19];

   initial begin
      // Vector table: first spawn, idle cycle, 16 ticks at speed 4, idle cycle.
      vecs[0] = '{1'b1, 3'd1, 8'h7C, 3'b001, 10'd671, 10'd0, 1'b1};
      vecs[1] = '{1'b0, 3'd1, 8'h7C, 3'b001, 10'd671, 10'd0, 1'b0};
      for (int k = 1; k <= 16; k++) begin
         vecs[1+k] = '{1'b1, 3'd4, 8'h05, (k == 16) ? 3'b011 : 3'b001,
                       10'(671 - 4*k), (k == 16) ? 10'd641 : 10'd0, (k == 16)};
      end
      vecs[18] = '{1'b0, 3'd4, 8'h05, 3'b011, 10'd607, 10'd641, 1'b0};

      tick = 0; halt = 0; speed = 0; spawn_en = 1; rng = 0; rst_n = 0;
      @(negedge clk);
      cyc(0, 0, 0, 1, 0, 0, "rst");
      cyc(1, 0, 1, 1, 8'h7C, 0, "rst_tick");
      chk("reset_active", bus0.obj_active, 0);
      chk("reset_pos", bus0.obj_pos, 0);
      chk("reset_type", bus0.obj_type, 0);
      chk("reset_pulse", bus0.spawn_pulse, 0);

      for (int v = 0; v < 19; v++) begin
         cyc(vecs[v].tick, 0, vecs[v].speed, 1, vecs[v].rng, 1, "vec");
         chk($sformatf("vec%0d_act", v), bus0.obj_active, vecs[v].exp_act);
         chk($sformatf("vec%0d_pos0", v), slot_pos(0), vecs[v].exp_pos0);
         chk($sformatf("vec%0d_pos1", v), slot_pos(1), vecs[v].exp_pos1);
         chk($sformatf("vec%0d_pulse", v), bus0.spawn_pulse, vecs[v].exp_pulse);
         if (v == 0) begin
            chk("conv2_slot0", bus2.obj_pos[7:0], 167);
            chk("type_slot0", bus0.obj_type[1:0], 0);
            chk("slot2_idle", slot_pos(2), 0);
         end
      end
      $display("[TB] directed vector table done");

      // Despawn at pos 3 with slot 0 the only candidate, then respawn into it.
      cyc(0, 0, 0, 1, 0, 0, "s3_rst");
      cyc(1, 0, 1, 1, 8'h00, 1, "s3_spawn0");
      for (int k = 0; k < 32; k++) cyc(1, 0, 4, 1, 8'h00, 1, "s3_fill");
      chk("s3_full", bus0.obj_active, 3'b111);
      for (int k = 0; k < 72; k++) cyc(1, 0, 7, 1, 8'h00, 1, "s3_run");
      cyc(1, 0, 5, 1, 8'h00, 1, "s3_to3");
      chk("s3_pos0_is3", slot_pos(0), 3);
      cyc(1, 0, 4, 1, 8'h00, 1, "s3_despawn");
      chk("s3_desp_act", bus0.obj_active, 3'b110);
      chk("s3_desp_pos0", slot_pos(0), 0);
      chk("s3_no_spawn", bus0.spawn_pulse, 0);
      cyc(1, 0, 4, 1, 8'h00, 1, "s3_respawn");
      chk("s3_resp_act", bus0.obj_active, 3'b111);
      chk("s3_resp_pos0", slot_pos(0), 640);
      chk("s3_resp_pulse", bus0.spawn_pulse, 1);
      $display("[TB] despawn/respawn sequence done");

      // Full array idles without spawning; slot 1 frees and is refilled first.
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, 1, 8'h00, 1, "s5_idle");
         chk("s5_idle_pulse", bus0.spawn_pulse, 0);
      end
      for (int k = 0; k < 8; k++) cyc(1, 0, 7, 1, 8'h00, 1, "s5_run");
      chk("s5_pos1_is3", slot_pos(1), 3);
      cyc(1, 0, 7, 1, 8'h00, 1, "s5_desp1");
      chk("s5_desp_act", bus0.obj_active, 3'b101);
      cyc(1, 0, 7, 1, 8'h00, 1, "s5_resp1");
      chk("s5_resp_act", bus0.obj_active, 3'b111);
      chk("s5_resp_pos1", slot_pos(1), 640);
      chk("s5_resp_pos2", slot_pos(2), 53);
      chk("s5_resp_pulse", bus0.spawn_pulse, 1);
      $display("[TB] full-array / lowest-slot sequence done");

      // Halt overrides tick, both before the first spawn and mid-motion.
      cyc(0, 0, 0, 1, 0, 0, "s4_rst");
      for (int k = 0; k < 5; k++) begin
         cyc(1, 1, 3, 1, 8'h7C, 1, "s4_halt");
         chk("s4_halt_act", bus0.obj_active, 0);
         chk("s4_halt_pulse", bus0.spawn_pulse, 0);
      end
      cyc(1, 0, 3, 1, 8'h7C, 1, "s4_release");
      chk("s4_rel_pos0", slot_pos(0), 671);
      chk("s4_rel_pulse", bus0.spawn_pulse, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(1, 1, 3, 1, 8'h7C, 1, "s4_halt2");
         chk("s4_halt2_pos0", slot_pos(0), 671);
      end
      cyc(1, 0, 3, 1, 8'h7C, 1, "s4_move");
      chk("s4_move_pos0", slot_pos(0), 668);
      $display("[TB] halt sequence done");

      // Reset mid-scroll with tick high, then first tick spawns into slot 0.
      cyc(1, 0, 3, 1, 8'h00, 0, "s6_rst");
      chk("s6_rst_act", bus0.obj_active, 0);
      chk("s6_rst_pos", bus0.obj_pos, 0);
      chk("s6_rst_c2pos", bus2.obj_pos, 0);
      cyc(1, 0, 2, 1, 8'h7C, 1, "s6_spawn");
      chk("s6_spawn_act", bus0.obj_active, 3'b001);
      chk("s6_c2_slot0", bus2.obj_pos[7:0], 167);
      $display("[TB] mid-scroll reset sequence done");

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             8'($urandom), ($urandom_range(0, 499) != 0), "rnd");
      end
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
